// File: rtl/icache_miss_ctrl_lv1_il_if.sv
// Bundles the CPU fetch, tag-compare, LRU and L2 signals of the L1-IL miss sequencer.
// The sequencer connects through "slave"; the CPU/L2/LRU side uses "master".
interface icache_miss_ctrl_lv1_il_if #(
    parameter int ASSOC_WID = 4,
    parameter int ADDR_WID  = 32,
    parameter int CNT_WID   = 16
);
    logic                 cpu_rd;
    logic                 cpu_wr;
    logic [ADDR_WID-1:0]  addr_bus_cpu_lv1;
    logic                 tag_hit;
    logic [ASSOC_WID-1:0] hit_way;
    logic [ASSOC_WID-1:0] lru_replacement_proc;
    logic                 lv2_rd;
    logic [ADDR_WID-1:0]  lv2_addr;
    logic                 lv2_rd_done;
    logic                 fill_en;
    logic [ASSOC_WID-1:0] fill_way;
    logic [ASSOC_WID-1:0] blk_accessed_main;
    logic                 lru_update;
    logic                 cpu_rd_done;
    logic                 illegal_wr;
    logic [CNT_WID-1:0]   miss_cnt;

    modport master (
        output cpu_rd, cpu_wr, addr_bus_cpu_lv1, tag_hit, hit_way,
               lru_replacement_proc, lv2_rd_done,
        input  lv2_rd, lv2_addr, fill_en, fill_way, blk_accessed_main,
               lru_update, cpu_rd_done, illegal_wr, miss_cnt
    );

    modport slave (
        input  cpu_rd, cpu_wr, addr_bus_cpu_lv1, tag_hit, hit_way,
               lru_replacement_proc, lv2_rd_done,
        output lv2_rd, lv2_addr, fill_en, fill_way, blk_accessed_main,
               lru_update, cpu_rd_done, illegal_wr, miss_cnt
    );
endinterface

// File: rtl/icache_miss_ctrl_lv1_il.sv
// L1 instruction-cache access sequencer: answers hits in one cycle, and on a miss
// latches the victim way, reads the block from L2 (reissuing on timeout), fills
// the arrays and strobes the LRU update once per completed access.
module icache_miss_ctrl_lv1_il #(
    parameter int ASSOC_WID  = 4,
    parameter int ADDR_WID   = 32,
    parameter int OFFSET_MSB = 5,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WID    = 16
) (
    input logic                      clk,
    input logic                      rst,
    icache_miss_ctrl_lv1_il_if.slave bus
);
    localparam int TMR_WID = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT_L2, FILL, RESP} state_t;

    state_t               state_q;
    logic [ADDR_WID-1:0]  addr_q;
    logic [ASSOC_WID-1:0] way_q;
    logic [TMR_WID-1:0]   tmr_q;
    logic                 lv2_rd_q;
    logic                 fill_en_q;
    logic [ASSOC_WID-1:0] fill_way_q;
    logic                 lru_update_q;
    logic [ASSOC_WID-1:0] blk_q;
    logic                 done_q;
    logic                 illegal_wr_q;
    logic [CNT_WID-1:0]   miss_cnt_q;

    // Lowest set bit of the LRU vector; an empty vector falls back to way 0.
    function automatic logic [ASSOC_WID-1:0] pick_victim(input logic [ASSOC_WID-1:0] v);
        logic [ASSOC_WID-1:0] r;
        r = ASSOC_WID'(1);
        for (int i = ASSOC_WID - 1; i >= 0; i--)
            if (v[i]) r = ASSOC_WID'(1) << i;
        return r;
    endfunction

    // Block-aligned L2 address: offset bits cleared.
    function automatic logic [ADDR_WID-1:0] block_align(input logic [ADDR_WID-1:0] a);
        logic [ADDR_WID-1:0] r;
        r = a;
        r[OFFSET_MSB:0] = '0;
        return r;
    endfunction

    // Miss counter increment that sticks at all-ones.
    function automatic logic [CNT_WID-1:0] sat_inc(input logic [CNT_WID-1:0] c);
        return (&c) ? c : c + CNT_WID'(1);
    endfunction

    // Access sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            way_q        <= '0;
            tmr_q        <= '0;
            lv2_rd_q     <= 1'b0;
            fill_en_q    <= 1'b0;
            fill_way_q   <= '0;
            lru_update_q <= 1'b0;
            blk_q        <= '0;
            done_q       <= 1'b0;
            illegal_wr_q <= 1'b0;
            miss_cnt_q   <= '0;
        end else begin
            if (bus.cpu_wr) illegal_wr_q <= 1'b1;
            fill_en_q    <= 1'b0;
            fill_way_q   <= '0;
            lru_update_q <= 1'b0;
            blk_q        <= '0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_rd) begin
                        if (bus.tag_hit) begin
                            way_q        <= bus.hit_way;
                            lru_update_q <= 1'b1;
                            blk_q        <= bus.hit_way;
                            done_q       <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            addr_q   <= block_align(bus.addr_bus_cpu_lv1);
                            way_q    <= pick_victim(bus.lru_replacement_proc);
                            lv2_rd_q <= 1'b1;
                            state_q  <= REQ;
                        end
                    end
                end
                REQ: begin
                    tmr_q    <= '0;
                    // With a one-cycle timeout the first wait cycle is already the drop cycle.
                    lv2_rd_q <= (TIMEOUT > 1);
                    state_q  <= WAIT_L2;
                end
                WAIT_L2: begin
                    if (bus.lv2_rd_done) begin
                        lv2_rd_q   <= 1'b0;
                        fill_en_q  <= 1'b1;
                        fill_way_q <= way_q;
                        state_q    <= FILL;
                    end else if (tmr_q == TMR_WID'(TIMEOUT - 1)) begin
                        lv2_rd_q <= 1'b1;
                        state_q  <= REQ;
                    end else begin
                        tmr_q    <= tmr_q + TMR_WID'(1);
                        // Request drops for the final wait cycle before the reissue.
                        lv2_rd_q <= (tmr_q != TMR_WID'(TIMEOUT - 2));
                    end
                end
                FILL: begin
                    miss_cnt_q   <= sat_inc(miss_cnt_q);
                    lru_update_q <= 1'b1;
                    blk_q        <= way_q;
                    // An abandoned fetch still updates the LRU but gets no done pulse.
                    done_q       <= bus.cpu_rd;
                    state_q      <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.lv2_rd            = lv2_rd_q;
    assign bus.lv2_addr          = addr_q;
    assign bus.fill_en           = fill_en_q;
    assign bus.fill_way          = fill_way_q;
    assign bus.blk_accessed_main = blk_q;
    assign bus.lru_update        = lru_update_q;
    assign bus.cpu_rd_done       = done_q;
    assign bus.illegal_wr        = illegal_wr_q;
    assign bus.miss_cnt          = miss_cnt_q;
endmodule

// File: tb/tb_icache_miss_ctrl_lv1_il.sv
// Randomised and directed bench for icache_miss_ctrl_lv1_il with a transaction-level
// reference: each access is expanded into its expected per-cycle outputs.
module tb_icache_miss_ctrl_lv1_il;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int TO  = 8;
    localparam int NV  = 1 + 1 + AW + 1 + AW + 1 + 1 + CW;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic ill_exp = 1'b0;
    logic [CW-1:0] cnt_exp = '0;
    bit   wr_rand = 1'b0;

    icache_miss_ctrl_lv1_il_if #(.ASSOC_WID(AW), .ADDR_WID(DW), .CNT_WID(CW)) intf ();

    icache_miss_ctrl_lv1_il #(
        .ASSOC_WID(AW), .ADDR_WID(DW), .OFFSET_MSB(5), .TIMEOUT(TO), .CNT_WID(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Victim rule: lowest-numbered way flagged by the LRU block, way 0 if none.
    function automatic logic [AW-1:0] model_victim(input logic [AW-1:0] lru);
        for (int i = 0; i < AW; i++)
            if (lru[i]) return AW'(1) << i;
        return AW'(1);
    endfunction

    // Advance one full cycle, negedge to negedge; a write seen at the edge makes illegal_wr sticky.
    task automatic tick();
        bit wp;
        wp = intf.cpu_wr;
        @(negedge clk);
        if (wp) ill_exp = 1'b1;
        intf.cpu_wr = wr_rand ? ($urandom_range(0, 7) == 0) : 1'b0;
    endtask

    task automatic check_cycle(input string tag, input logic e_rd, input logic e_fill,
                               input logic [AW-1:0] e_fw, input logic e_lru,
                               input logic [AW-1:0] e_blk, input logic e_done);
        logic [NV-1:0] obs, exp;
        obs = {intf.lv2_rd, intf.fill_en, intf.fill_way, intf.lru_update,
               intf.blk_accessed_main, intf.cpu_rd_done, intf.illegal_wr, intf.miss_cnt};
        exp = {e_rd, e_fill, e_fw, e_lru, e_blk, e_done, ill_exp, cnt_exp};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s outputs observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_addr(input string tag, input logic [DW-1:0] e);
        checks++;
        assert (intf.lv2_addr === e) else begin
            errors++;
            $error("FAIL %s lv2_addr observed=%h expected=%h", tag, intf.lv2_addr, e);
        end
    endtask

    task automatic check_idle(input string tag);
        check_cycle(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic scramble();
        intf.addr_bus_cpu_lv1     = $urandom;
        intf.lru_replacement_proc = AW'($urandom);
        intf.tag_hit              = 1'($urandom);
        intf.hit_way              = AW'($urandom);
    endtask

    task automatic do_hit(input string tag, input logic [DW-1:0] a, input logic [AW-1:0] hw);
        intf.cpu_rd = 1'b1;
        intf.tag_hit = 1'b1;
        intf.hit_way = hw;
        intf.addr_bus_cpu_lv1 = a;
        intf.lru_replacement_proc = AW'($urandom);
        tick();
        check_cycle({tag, "_resp"}, 1'b0, 1'b0, '0, 1'b1, hw, 1'b1);
        intf.cpu_rd = 1'b0;
        intf.tag_hit = 1'b0;
        tick();
        check_idle({tag, "_idle"});
    endtask

    // R=request, W=waiting, L=timeout drop cycle, D=waiting with L2 done, F=fill, S=response.
    task automatic do_miss(input string tag, input logic [DW-1:0] a, input logic [AW-1:0] lru,
                           input int retries, input int w, input bit keep, input bit spur);
        logic [DW-1:0] ea;
        logic [AW-1:0] ev;
        byte q[$];
        byte k;
        logic e_rd, e_f, e_l;
        ea = a & ~DW'(63);
        ev = model_victim(lru);
        for (int r = 0; r < retries; r++) begin
            q.push_back("R");
            for (int i = 0; i < TO - 1; i++) q.push_back("W");
            q.push_back("L");
        end
        q.push_back("R");
        for (int i = 0; i < w; i++) q.push_back("W");
        q.push_back("D");
        q.push_back("F");
        q.push_back("S");

        intf.cpu_rd = 1'b1;
        intf.tag_hit = 1'b0;
        intf.addr_bus_cpu_lv1 = a;
        intf.lru_replacement_proc = lru;
        tick();
        foreach (q[i]) begin
            k = q[i];
            scramble();
            e_rd = (k == "R") || (k == "W") || (k == "D");
            e_f  = (k == "F");
            e_l  = (k == "S");
            if (e_l && cnt_exp != {CW{1'b1}}) cnt_exp = cnt_exp + CW'(1);
            check_cycle({tag, "_", string'(k)}, e_rd, e_f, e_f ? ev : '0, e_l, e_l ? ev : '0,
                        e_l && keep);
            if (e_rd) check_addr({tag, "_addr"}, ea);
            intf.lv2_rd_done = (k == "D") || (spur && (k == "R" || k == "F"));
            if (!keep && k == "D") intf.cpu_rd = 1'b0;
            if (k == "S") begin
                intf.cpu_rd = 1'b0;
                intf.lv2_rd_done = 1'b0;
            end
            tick();
        end
        intf.tag_hit = 1'b0;
        check_idle({tag, "_idle"});
    endtask

    initial begin
        rst = 1'b1;
        intf.cpu_rd = 1'b0;
        intf.cpu_wr = 1'b0;
        intf.addr_bus_cpu_lv1 = '0;
        intf.tag_hit = 1'b0;
        intf.hit_way = '0;
        intf.lru_replacement_proc = '0;
        intf.lv2_rd_done = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check_addr("reset", '0);
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        do_hit("hit", 32'h0000_1044, 4'b0100);
        do_miss("miss", 32'h0000_2FFC, 4'b0010, 0, 2, 1'b1, 1'b0);
        do_miss("timeout", 32'h0000_5A17, 4'b1000, 1, 1, 1'b1, 1'b0);
        do_miss("victim0110", 32'h0001_00C3, 4'b0110, 0, 0, 1'b1, 1'b1);
        do_miss("victim0000", 32'h0001_0123, 4'b0000, 0, 0, 1'b1, 1'b0);
        do_miss("abandon", 32'h0002_3456, 4'b0001, 0, 3, 1'b0, 1'b0);

        intf.cpu_wr = 1'b1;
        tick();
        check_idle("illegal_wr_set");
        tick();
        check_idle("illegal_wr_sticky");

        force dut.miss_cnt_q = 16'hFFFF;
        tick();
        release dut.miss_cnt_q;
        cnt_exp = 16'hFFFF;
        check_idle("preload");
        do_miss("saturate", 32'h0003_0040, 4'b0100, 0, 1, 1'b1, 1'b0);

        wr_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0)
                do_hit("rnd_hit", $urandom, AW'(1) << $urandom_range(0, AW - 1));
            else
                do_miss("rnd_miss", $urandom, AW'($urandom), $urandom_range(0, 2),
                        $urandom_range(0, TO - 2), ($urandom_range(0, 3) != 0), 1'($urandom));
        end
        wr_rand = 1'b0;
        intf.cpu_wr = 1'b0;
        tick();

        intf.cpu_rd = 1'b1;
        intf.tag_hit = 1'b0;
        intf.addr_bus_cpu_lv1 = 32'h0004_4444;
        intf.lru_replacement_proc = 4'b1000;
        tick();
        tick();
        check_cycle("rst_mid_wait", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        ill_exp = 1'b0;
        cnt_exp = '0;
        check_idle("rst_async");
        check_addr("rst_async", '0);
        intf.cpu_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        intf.lv2_rd_done = 1'b1;
        tick();
        intf.lv2_rd_done = 1'b0;
        check_idle("late_done_ignored");
        tick();
        check_idle("late_done_idle");
        check_addr("late_done_idle", '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_miss_ctrl_lv1_il.md
Name: icache_miss_ctrl_lv1_il

Overview:
Per-core L1 instruction-cache access sequencer that sits directly upstream of the L1-IL cache controller/LRU block. It accepts CPU instruction fetches and takes the tag-compare result. On a hit it responds to the CPU. On a miss it latches the LRU victim way, issues a block read to L2, sequences the one-cycle array fill, and then drives blk_accessed_main and lru_update into the controller so the LRU state is updated once per completed access.

Parameters:
ASSOC_WID, 4, number of ways; all way vectors are one-hot of this width
ADDR_WID, 32, CPU address width
OFFSET_MSB, 5, block-offset MSB; bits [OFFSET_MSB:0] are zeroed on the L2 request address
TIMEOUT, 64, cycles in WAIT_L2 before the L2 request is reissued
CNT_WID, 16, width of the miss counter

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
cpu_rd  input  1  instruction fetch request; held high until cpu_rd_done
cpu_wr  input  1  write request; illegal for an I-cache
addr_bus_cpu_lv1  input  ADDR_WID  fetch address, stable while cpu_rd is high
tag_hit  input  1  combinational tag-compare hit for addr_bus_cpu_lv1
hit_way  input  ASSOC_WID  one-hot matching way, valid when tag_hit=1
lru_replacement_proc  input  ASSOC_WID  victim way from the LRU block
lv2_rd  output  1  block read request to L2
lv2_addr  output  ADDR_WID  block-aligned miss address
lv2_rd_done  input  1  L2 data valid/ack; 1-cycle pulse
fill_en  output  1  write the L2 block into the data/tag arrays
fill_way  output  ASSOC_WID  one-hot way to fill
blk_accessed_main  output  ASSOC_WID  accessed way presented to the LRU block
lru_update  output  1  1-cycle LRU update strobe
cpu_rd_done  output  1  1-cycle fetch completion pulse
illegal_wr  output  1  sticky; set by any cpu_wr
miss_cnt  output  CNT_WID  saturating count of completed misses

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs are 0, including lv2_addr, fill_way, blk_accessed_main, miss_cnt and illegal_wr. Latched address, victim and timeout counter are 0. Reset mid-transaction abandons it with no further L2 or fill activity.
- FSM states: IDLE, REQ, WAIT_L2, FILL, RESP.
- IDLE with cpu_rd=1 and tag_hit=1: go to RESP and latch way_q=hit_way. Hit latency is 1 cycle (done in the cycle after the request).
- IDLE with cpu_rd=1 and tag_hit=0:
  - latch addr_q = addr with offset bits zeroed.
  - latch way_q = lowest set bit of lru_replacement_proc; if that vector is all-zero, use way 0 (one-hot 0001).
  - go to REQ.
- REQ: lv2_rd=1, lv2_addr=addr_q. Clear the timeout counter and go to WAIT_L2.
- WAIT_L2:
  - lv2_rd stays 1 and the counter increments each cycle.
  - If lv2_rd_done=1, go to FILL.
  - If the counter reaches TIMEOUT-1 without done, drive lv2_rd=0 for that cycle and go to REQ (reissue). There is no retry limit.
  - lv2_rd_done outside WAIT_L2 is ignored.
- FILL: for one cycle, fill_en=1 and fill_way=way_q. Increment miss_cnt, saturating at all-ones. Go to RESP.
- RESP: for one cycle, lru_update=1 and blk_accessed_main=way_q.
  - cpu_rd_done=1 only if cpu_rd is still high; if the CPU dropped cpu_rd mid-miss, the fill and LRU update still complete but no done pulse is issued.
  - Return to IDLE. A new request is accepted no earlier than the cycle after RESP.
- Miss latency (request to done) = 3 + L2 wait cycles; minimum 4 when L2 responds in its first WAIT_L2 cycle.
- fill_way and blk_accessed_main read 0 outside FILL and RESP respectively.
- cpu_wr: in any state, sets illegal_wr. It never starts a transaction and does not disturb one in flight. If cpu_rd and cpu_wr are high in the same IDLE cycle, the read is serviced and illegal_wr is set.
- Address and LRU-victim changes after the IDLE acceptance cycle are ignored; only the latched values are used.

Test Plan:
- Hit: addr=0x0000_1044, tag_hit=1, hit_way=0100 -> next cycle cpu_rd_done=1, lru_update=1, blk_accessed_main=0100; lv2_rd never asserted; miss_cnt=0.
- Miss: addr=0x0000_2FFC, tag_hit=0, lru_replacement_proc=0010, L2 done 3 cycles after lv2_rd rises -> lv2_addr=0x0000_2FC0; then fill_en with fill_way=0010; then RESP with lru_update=1, blk_accessed_main=0010, cpu_rd_done=1; miss_cnt=1.
- Timeout: miss with L2 silent for TIMEOUT=8 cycles -> lv2_rd drops for 1 cycle and reasserts with the same address; done on retry completes normally.
- Bad victim: lru_replacement_proc=0110 -> fill_way=0010; lru_replacement_proc=0000 -> fill_way=0001.
- Abandon and reset: drop cpu_rd during WAIT_L2 -> fill and lru_update still occur, cpu_rd_done stays 0. Assert rst mid-WAIT_L2 -> all outputs 0 immediately; a later done pulse is ignored.
- Write and saturation: pulse cpu_wr -> illegal_wr=1 until rst. Preload miss_cnt=0xFFFF (force) and complete one miss -> it stays 0xFFFF.
